// File: rtl/matmul_sequencer.sv
// Sequencer for an M x N x K matrix multiply: launches one dot product per result
// element, waits for it with a watchdog, writes the result, and walks row/column bases.
module matmul_sequencer #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        dim_m,
    input  logic [7:0]        dim_n,
    input  logic [7:0]        dim_k,
    input  logic              mac_done,
    input  logic              wr_ready,
    output logic              mac_start,
    output logic [7:0]        mac_len,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [ADDR_W-1:0] res_addr,
    output logic              wr_valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       count
);

    localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_WRITE   = 3'd3,
        S_ADVANCE = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        m_q, m_d, n_q, n_d, k_q, k_d;
    logic [7:0]        row_q, row_d, col_q, col_d;
    logic [15:0]       count_q, count_d;
    logic [ADDR_W-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            n_q     <= n_d;
            k_q     <= k_d;
            row_q   <= row_d;
            col_q   <= col_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        n_d       = n_q;
        k_d       = k_q;
        row_d     = row_q;
        col_d     = col_q;
        count_d   = count_q;
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        wd_d      = wd_q;
        err_d     = err_q;
        mac_start = 1'b0;
        wr_valid  = 1'b0;
        done      = 1'b0;
        err       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = dim_m;
                    n_d     = dim_n;
                    k_d     = dim_k;
                    row_d   = '0;
                    col_d   = '0;
                    count_d = '0;
                    a_d     = '0;
                    b_d     = '0;
                    r_d     = '0;
                    wd_d    = '0;
                    if (dim_m == 8'd0 || dim_n == 8'd0 || dim_k == 8'd0) begin
                        err_d   = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                mac_start = 1'b1;
                wd_d      = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (mac_done) begin
                    state_d = S_WRITE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if (wd_d == WD_W'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_FINISH;
                    end
                end
            end
            S_WRITE: begin
                wr_valid = 1'b1;
                if (wr_ready) begin
                    count_d = count_q + 16'd1;
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                // Bases step by K so A is row-major and B column-major without a multiplier.
                if (col_q != n_q - 8'd1) begin
                    col_d   = col_q + 8'd1;
                    b_d     = b_q + ADDR_W'(k_q);
                    r_d     = r_q + ADDR_W'(1);
                    state_d = S_ISSUE;
                end else if (row_q != m_q - 8'd1) begin
                    col_d   = '0;
                    b_d     = '0;
                    row_d   = row_q + 8'd1;
                    a_d     = a_q + ADDR_W'(k_q);
                    r_d     = r_q + ADDR_W'(1);
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                err     = err_q;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a same-cycle handshake; count is kept.
        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            count_d   = count_q;
            wd_d      = '0;
            err_d     = 1'b0;
            mac_start = 1'b0;
            wr_valid  = 1'b0;
            done      = 1'b0;
            err       = 1'b0;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign mac_len  = busy ? k_q : 8'd0;
    assign a_addr   = a_q;
    assign b_addr   = b_q;
    assign res_addr = r_q;
    assign count    = count_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: a per-cycle reference model of the loop nest
// plus hand-computed expectations for each scenario.
module tb_matmul_sequencer;

    localparam int TMO = 10;

    logic        clk = 1'b0;
    logic        reset, start, abort, mac_done, wr_ready;
    logic [7:0]  dim_m, dim_n, dim_k;
    logic        mac_start, wr_valid, busy, done, err;
    logic [7:0]  mac_len;
    logic [15:0] a_addr, b_addr, res_addr, count;

    matmul_sequencer #(.ADDR_W(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .dim_m(dim_m), .dim_n(dim_n), .dim_k(dim_k),
        .mac_done(mac_done), .wr_ready(wr_ready),
        .mac_start(mac_start), .mac_len(mac_len),
        .a_addr(a_addr), .b_addr(b_addr), .res_addr(res_addr),
        .wr_valid(wr_valid), .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Responder state
    int mac_lat = 5;
    int mac_cnt = 0;
    bit withhold = 1'b0;
    int stall_left = 0;

    // Observation log
    int n_launch, n_write, n_done, n_err, n_err_alone, n_wv_first, n_res_move;
    int start_cyc, done_cyc, cyc;
    int la[$], lb[$], lr[$];

    // Reference model state
    int m_m, m_n, m_k, m_launch, m_writes, m_count, m_due, m_wcnt;
    bit m_err, m_waiting, exp_done;

    task automatic clear_log();
        n_launch = 0; n_write = 0; n_done = 0; n_err = 0; n_err_alone = 0;
        n_wv_first = 0; n_res_move = 0; start_cyc = 0; done_cyc = 0;
        la.delete(); lb.delete(); lr.delete();
    endtask

    initial begin : responder
        mac_done = 1'b0;
        wr_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                mac_cnt = 0;
            end else begin
                if (mac_start) mac_cnt = mac_lat;
                if (wr_valid && stall_left > 0) stall_left--;
            end
            @(posedge clk);
            #1;
            mac_done = 1'b0;
            if (mac_cnt > 0) begin
                mac_cnt--;
                if (mac_cnt == 0 && !withhold) mac_done = 1'b1;
            end
            wr_ready = (stall_left == 0);
        end
    end

    initial begin : monitor
        m_m = 0; m_n = 0; m_k = 0; m_launch = 0; m_writes = 0; m_count = 0;
        m_due = 0; m_wcnt = 0; m_err = 1'b0; m_waiting = 1'b0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                chk("rst_busy", 32'(busy), 0);
                chk("rst_ctrl", 32'({mac_start, wr_valid, done, err}), 0);
                chk("rst_count", 32'(count), 0);
                chk("rst_addr", 32'(a_addr) + 32'(b_addr) + 32'(res_addr), 0);
                chk("rst_mac_len", 32'(mac_len), 0);
                m_k = 0; m_count = 0; m_due = 0; m_waiting = 1'b0; m_err = 1'b0;
            end else begin
                exp_done = (m_due == 1);
                if (m_due > 0) m_due--;
                chk("count", 32'(count), m_count);
                chk("mac_len", 32'(mac_len), busy ? m_k : 0);
                chk("done", 32'(done), 32'(exp_done));
                chk("err", 32'(err), 32'(exp_done && m_err));
                if (wr_valid && n_write == 0) begin
                    n_wv_first++;
                    if (res_addr != 16'd0) n_res_move++;
                end
                if (busy && abort) begin
                    chk("abort_mac_start", 32'(mac_start), 0);
                    chk("abort_wr_valid", 32'(wr_valid), 0);
                    m_due = 0;
                    m_waiting = 1'b0;
                end else begin
                    if (m_waiting) begin
                        if (mac_done) begin
                            m_waiting = 1'b0;
                        end else begin
                            m_wcnt++;
                            if (m_wcnt == TMO) begin
                                m_waiting = 1'b0;
                                m_due = 1;
                                m_err = 1'b1;
                            end
                        end
                    end
                    if (mac_start) begin
                        chk("launch_in_range", 32'(m_launch < m_m * m_n), 1);
                        chk("a_addr", 32'(a_addr), ((m_launch / (m_n > 0 ? m_n : 1)) * m_k) & 16'hFFFF);
                        chk("b_addr", 32'(b_addr), ((m_launch % (m_n > 0 ? m_n : 1)) * m_k) & 16'hFFFF);
                        la.push_back(int'(a_addr));
                        lb.push_back(int'(b_addr));
                        n_launch++;
                        start_cyc = cyc;
                        m_launch++;
                        m_waiting = 1'b1;
                        m_wcnt = 0;
                    end
                    if (wr_valid) begin
                        chk("res_addr", 32'(res_addr), m_writes);
                        if (wr_ready) begin
                            lr.push_back(int'(res_addr));
                            n_write++;
                            m_writes++;
                            m_count++;
                            if (m_writes == m_m * m_n) m_due = 2;
                        end
                    end
                    if (!busy && start) begin
                        m_m = int'(dim_m); m_n = int'(dim_n); m_k = int'(dim_k);
                        m_launch = 0; m_writes = 0; m_count = 0; m_waiting = 1'b0;
                        m_err = (m_m == 0 || m_n == 0 || m_k == 0);
                        m_due = m_err ? 1 : 0;
                    end
                end
                if (done) begin n_done++; done_cyc = cyc; end
                if (err) n_err++;
                if (err && !done) n_err_alone++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int m, input int n, input int k);
        dim_m = 8'(m); dim_n = 8'(n); dim_k = 8'(k);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int t = 0;
        while (busy && t < budget) begin tick(); t++; end
        chk({name, "_idle"}, 32'(busy), 0);
    endtask

    initial begin : stimulus
        int ea[6] = '{0, 0, 0, 4, 4, 4};
        int eb[6] = '{0, 4, 8, 0, 4, 8};
        int t;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        dim_m = '0; dim_n = '0; dim_k = '0;
        clear_log();
        repeat (3) tick();
        chk("reset_busy", 32'(busy), 0);
        chk("reset_count", 32'(count), 0);
        chk("reset_res_addr", 32'(res_addr), 0);
        reset = 1'b0;
        tick();

        // 2x3x4 full run
        clear_log();
        do_start(2, 3, 4);
        wait_idle(500, "run234");
        chk("run234_launches", n_launch, 6);
        chk("run234_writes", n_write, 6);
        for (int i = 0; i < 6; i++) begin
            chk("run234_a", (i < la.size()) ? la[i] : -1, ea[i]);
            chk("run234_b", (i < lb.size()) ? lb[i] : -1, eb[i]);
            chk("run234_res", (i < lr.size()) ? lr[i] : -1, i);
        end
        chk("run234_count", 32'(count), 6);
        chk("run234_done", n_done, 1);
        chk("run234_err", n_err, 0);

        // zero dimension
        clear_log();
        do_start(2, 0, 3);
        wait_idle(20, "zero_n");
        chk("zero_n_launches", n_launch, 0);
        chk("zero_n_done", n_done, 1);
        chk("zero_n_err", n_err, 1);
        chk("zero_n_err_alone", n_err_alone, 0);

        // withheld mac_done -> timeout
        withhold = 1'b1;
        clear_log();
        do_start(1, 1, 1);
        wait_idle(100, "timeout");
        withhold = 1'b0;
        chk("timeout_launches", n_launch, 1);
        chk("timeout_writes", n_write, 0);
        chk("timeout_done", n_done, 1);
        chk("timeout_err", n_err, 1);
        chk("timeout_gap", done_cyc - start_cyc, TMO + 1);

        // write back-pressure on first result
        stall_left = 7;
        clear_log();
        do_start(1, 2, 3);
        wait_idle(200, "stall");
        chk("stall_wv_cycles", n_wv_first, 8);
        chk("stall_res_moved", n_res_move, 0);
        chk("stall_writes", n_write, 2);
        chk("stall_count", 32'(count), 2);
        chk("stall_done", n_done, 1);

        // abort during the third WAIT
        clear_log();
        do_start(2, 3, 4);
        t = 0;
        while (n_launch < 3 && t < 200) begin tick(); t++; end
        chk("abort_reached_third", n_launch, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_outs", 32'({mac_start, wr_valid, done, err}), 0);
        chk("abort_mac_len", 32'(mac_len), 0);
        chk("abort_count", 32'(count), 2);
        repeat (8) tick();
        chk("abort_no_done", n_done, 0);

        // reset asserted mid-WRITE
        stall_left = 20;
        clear_log();
        do_start(1, 1, 1);
        t = 0;
        while (!wr_valid && t < 50) begin tick(); t++; end
        chk("rstwr_in_write", 32'(wr_valid), 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rstwr_busy", 32'(busy), 0);
        chk("rstwr_wr_valid", 32'(wr_valid), 0);
        chk("rstwr_count", 32'(count), 0);
        chk("rstwr_addr", 32'(a_addr) + 32'(b_addr) + 32'(res_addr), 0);
        tick();
        stall_left = 0;
        tick();
        reset = 1'b0;
        tick();
        chk("rstwr_no_done", n_done, 0);

        // start re-asserted while busy, then 1x1x1
        clear_log();
        do_start(1, 3, 2);
        tick();
        do_start(4, 4, 4);
        repeat (5) tick();
        do_start(3, 3, 3);
        wait_idle(300, "rebusy");
        chk("rebusy_launches", n_launch, 3);
        chk("rebusy_writes", n_write, 3);
        chk("rebusy_b2", (lb.size() > 2) ? lb[2] : -1, 4);
        chk("rebusy_count", 32'(count), 3);
        chk("rebusy_done", n_done, 1);
        clear_log();
        do_start(1, 1, 1);
        wait_idle(50, "one");
        chk("one_launches", n_launch, 1);
        chk("one_writes", n_write, 1);
        chk("one_res", (lr.size() > 0) ? lr[0] : -1, 0);
        chk("one_done", n_done, 1);
        chk("one_err", n_err, 0);
        chk("one_count", 32'(count), 1);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : guard
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
